qos_dequeue_scheduler: RTL and testbench

Packet-granular dequeue scheduler for the two-queue QoS set. It decides which queue drains next, using either weighted round-robin or strict priority. It issues per-queue FIFO read enables and drives the grant (`queue_out_en`, `total_queue_out_en`) into the output mux, so the mux selects the correct queue's data word on the cycle that word is valid. Grants never change inside a packet.

---
 rtl/qos_sched_pkg.sv | 17 +
 rtl/qos_wrr_credit.sv | 73 +++++++
 rtl/qos_dequeue_scheduler.sv | 127 ++++++++++++
 tb/tb_qos_dequeue_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/qos_sched_pkg.sv
// Shared types and constants for the two-queue QoS dequeue scheduler.
package qos_sched_pkg;

  localparam int unsigned DEF_CREDIT_W = 8;
  localparam int unsigned DEF_STAT_W   = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DRAIN
  } sched_state_e;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_Q0   = 2'b01;
  localparam logic [1:0] GNT_Q1   = 2'b10;

endpackage

// File: rtl/qos_wrr_credit.sv
// Weighted round-robin credit counters, pointer, reload and pick logic.
module qos_wrr_credit
  import qos_sched_pkg::*;
#(
  parameter int unsigned CREDIT_W = DEF_CREDIT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arb_en_i,
  input  logic [1:0]          queue_empty_i,
  input  logic [CREDIT_W-1:0] weight_0_i,
  input  logic [CREDIT_W-1:0] weight_1_i,
  input  logic                done_i,
  input  logic                done_q_i,
  output logic [1:0]          pick_o,
  output logic                reload_o
);

  logic [CREDIT_W-1:0] cred_0_q, cred_0_d, cred_1_q, cred_1_d;
  logic [CREDIT_W-1:0] cred_dec;
  logic                ptr_q, ptr_d;
  logic [1:0]          eligible;

  assign eligible = ~queue_empty_i & {cred_1_q != '0, cred_0_q != '0};

  always_comb begin
    pick_o = GNT_NONE;
    if (arb_en_i) begin
      if (eligible[ptr_q]) begin
        pick_o = ptr_q ? GNT_Q1 : GNT_Q0;
      end else if (eligible[~ptr_q]) begin
        pick_o = ptr_q ? GNT_Q0 : GNT_Q1;
      end
    end
  end

  assign reload_o = arb_en_i && (eligible == 2'b00) && (queue_empty_i != 2'b11);

  always_comb begin
    cred_0_d = cred_0_q;
    cred_1_d = cred_1_q;
    ptr_d    = ptr_q;
    cred_dec = done_q_i ? cred_1_q : cred_0_q;
    if (cred_dec != '0) begin
      cred_dec = cred_dec - CREDIT_W'(1);
    end
    if (reload_o) begin
      // A zero weight still earns one packet per round.
      cred_0_d = (weight_0_i == '0) ? CREDIT_W'(1) : weight_0_i;
      cred_1_d = (weight_1_i == '0) ? CREDIT_W'(1) : weight_1_i;
    end else if (done_i) begin
      if (done_q_i) begin
        cred_1_d = cred_dec;
      end else begin
        cred_0_d = cred_dec;
      end
      ptr_d = (cred_dec != '0) ? done_q_i : ~done_q_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cred_0_q <= '0;
      cred_1_q <= '0;
      ptr_q    <= 1'b0;
    end else begin
      cred_0_q <= cred_0_d;
      cred_1_q <= cred_1_d;
      ptr_q    <= ptr_d;
    end
  end

endmodule

// File: rtl/qos_dequeue_scheduler.sv
// Packet-granular dequeue scheduler: WRR or strict priority over two queues,
// grant held for a whole packet, read enables and output-valid generation.
module qos_dequeue_scheduler
  import qos_sched_pkg::*;
#(
  parameter int unsigned CREDIT_W = DEF_CREDIT_W,
  parameter int unsigned STAT_W   = DEF_STAT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                strict_prio,
  input  logic [CREDIT_W-1:0] weight_0,
  input  logic [CREDIT_W-1:0] weight_1,
  input  logic [1:0]          queue_empty,
  input  logic [1:0]          queue_eop,
  input  logic                out_rdy,
  output logic [1:0]          queue_rd_en,
  output logic [1:0]          queue_out_en,
  output logic                total_queue_out_en,
  output logic                out_wr,
  output logic [STAT_W-1:0]   pkt_cnt_0,
  output logic [STAT_W-1:0]   pkt_cnt_1
);

  sched_state_e      state_q;
  logic [1:0]        gnt_q;
  logic              total_q;
  logic              strict_q;
  logic              out_wr_q;
  logic [STAT_W-1:0] pkt_cnt_0_q, pkt_cnt_1_q;

  logic [1:0] wrr_pick, strict_pick;
  logic       wrr_reload, arb_en, eop_rd, done;

  assign arb_en = (state_q == IDLE) && !strict_prio;

  always_comb begin
    queue_rd_en = 2'b00;
    if (state_q == SEND) begin
      queue_rd_en = gnt_q & ~queue_empty & {2{out_rdy}};
    end
  end

  assign eop_rd = |(queue_rd_en & queue_eop);
  // Credits only move for packets granted in WRR mode.
  assign done   = eop_rd && !strict_q;

  always_comb begin
    strict_pick = GNT_NONE;
    if (!queue_empty[1]) begin
      strict_pick = GNT_Q1;
    end else if (!queue_empty[0]) begin
      strict_pick = GNT_Q0;
    end
  end

  qos_wrr_credit #(
    .CREDIT_W(CREDIT_W)
  ) u_wrr_credit (
    .clk          (clk),
    .reset        (reset),
    .arb_en_i     (arb_en),
    .queue_empty_i(queue_empty),
    .weight_0_i   (weight_0),
    .weight_1_i   (weight_1),
    .done_i       (done),
    .done_q_i     (gnt_q[1]),
    .pick_o       (wrr_pick),
    .reload_o     (wrr_reload)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_NONE;
      total_q     <= 1'b0;
      strict_q    <= 1'b0;
      out_wr_q    <= 1'b0;
      pkt_cnt_0_q <= '0;
      pkt_cnt_1_q <= '0;
    end else begin
      out_wr_q <= |queue_rd_en;
      case (state_q)
        IDLE: begin
          if (strict_prio && (strict_pick != GNT_NONE)) begin
            gnt_q    <= strict_pick;
            total_q  <= 1'b1;
            strict_q <= 1'b1;
            state_q  <= SEND;
          end else if (!strict_prio && (wrr_pick != GNT_NONE)) begin
            gnt_q    <= wrr_pick;
            total_q  <= 1'b1;
            strict_q <= 1'b0;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (eop_rd) begin
            state_q <= DRAIN;
            if (gnt_q[1]) begin
              pkt_cnt_1_q <= pkt_cnt_1_q + STAT_W'(1);
            end else begin
              pkt_cnt_0_q <= pkt_cnt_0_q + STAT_W'(1);
            end
          end
        end
        DRAIN: begin
          gnt_q   <= GNT_NONE;
          total_q <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q   <= GNT_NONE;
          total_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign queue_out_en       = gnt_q;
  assign total_queue_out_en = total_q;
  assign out_wr             = out_wr_q;
  assign pkt_cnt_0          = pkt_cnt_0_q;
  assign pkt_cnt_1          = pkt_cnt_1_q;

endmodule

// File: tb/tb_qos_dequeue_scheduler.sv
// Directed bench for qos_dequeue_scheduler with a behavioural two-queue FIFO model.
module tb_qos_dequeue_scheduler;

  logic        clk;
  logic        reset;
  logic        strict_prio;
  logic [7:0]  weight_0, weight_1;
  logic [1:0]  queue_empty, queue_eop;
  logic        out_rdy;
  logic [1:0]  queue_rd_en, queue_out_en;
  logic        total_queue_out_en, out_wr;
  logic [15:0] pkt_cnt_0, pkt_cnt_1;

  qos_dequeue_scheduler dut (
    .clk               (clk),
    .reset             (reset),
    .strict_prio       (strict_prio),
    .weight_0          (weight_0),
    .weight_1          (weight_1),
    .queue_empty       (queue_empty),
    .queue_eop         (queue_eop),
    .out_rdy           (out_rdy),
    .queue_rd_en       (queue_rd_en),
    .queue_out_en      (queue_out_en),
    .total_queue_out_en(total_queue_out_en),
    .out_wr            (out_wr),
    .pkt_cnt_0         (pkt_cnt_0),
    .pkt_cnt_1         (pkt_cnt_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  bit fifo0[$];
  bit fifo1[$];
  logic [1:0] grant_log[$];
  int gstart[$];
  logic [1:0] s_rd, s_gnt, prev_gnt;
  logic s_ow;
  int cyc_n = 0;
  int done_cnt = 0;
  int ow_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic refresh();
    queue_empty = {fifo1.size() == 0, fifo0.size() == 0};
    queue_eop   = {fifo1.size() > 0 ? fifo1[0] : 1'b0, fifo0.size() > 0 ? fifo0[0] : 1'b0};
  endtask

  task automatic push_pkt(input int q, input int len);
    for (int i = 0; i < len; i++) begin
      if (q == 0) fifo0.push_back(i == len - 1);
      else        fifo1.push_back(i == len - 1);
    end
    refresh();
  endtask

  task automatic clear_log();
    grant_log.delete();
    gstart.delete();
    done_cnt = 0;
    ow_cnt   = 0;
    prev_gnt = 2'b00;
  endtask

  // Sample away from the edge, then pop the model FIFOs on the edge's reads.
  task automatic cyc();
    #1;
    s_rd  = queue_rd_en;
    s_gnt = queue_out_en;
    s_ow  = out_wr;
    if (s_ow) ow_cnt++;
    if (prev_gnt == 2'b00 && s_gnt != 2'b00) begin
      grant_log.push_back(s_gnt);
      gstart.push_back(cyc_n);
    end
    if (prev_gnt != 2'b00 && s_gnt == 2'b00) done_cnt++;
    prev_gnt = s_gnt;
    @(posedge clk);
    #1;
    if (s_rd[0] && fifo0.size() > 0) void'(fifo0.pop_front());
    if (s_rd[1] && fifo1.size() > 0) void'(fifo1.pop_front());
    refresh();
    cyc_n++;
  endtask

  task automatic do_reset();
    fifo0.delete();
    fifo1.delete();
    refresh();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    clear_log();
  endtask

  int bad_gnt, low_cnt, low_rd, rd_cnt, hold, stall;
  bit pushed0, pushed1;
  logic [1:0] exp_wrr[8] = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01, 2'b10};
  logic [1:0] exp_str[5] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b01};

  initial begin
    reset = 1'b1; strict_prio = 1'b0; weight_0 = 8'd1; weight_1 = 8'd1; out_rdy = 1'b1;
    refresh();
    do_reset();

    // Reset state
    check_eq("rst_gnt", queue_out_en, 2'b00);
    check_eq("rst_total", total_queue_out_en, 1'b0);
    check_eq("rst_rd", queue_rd_en, 2'b00);
    check_eq("rst_owr", out_wr, 1'b0);
    check_eq("rst_cnt0", pkt_cnt_0, 16'd0);
    check_eq("rst_cnt1", pkt_cnt_1, 16'd0);

    // WRR 3:1
    weight_0 = 8'd3; weight_1 = 8'd1;
    for (int i = 0; i < 8; i++) begin
      push_pkt(0, 1);
      push_pkt(1, 1);
    end
    for (int i = 0; i < 300 && done_cnt < 8; i++) cyc();
    check_eq("wrr_done", done_cnt, 8);
    for (int k = 0; k < 8; k++) check_eq($sformatf("wrr_gnt%0d", k), grant_log[k], exp_wrr[k]);
    check_eq("wrr_cnt0", pkt_cnt_0, 16'd6);
    check_eq("wrr_cnt1", pkt_cnt_1, 16'd2);
    check_eq("wrr_owr", ow_cnt, 8);

    // Strict priority, with a Q1 arrival during a Q0 packet
    strict_prio = 1'b1;
    do_reset();
    push_pkt(0, 2); push_pkt(0, 2);
    push_pkt(1, 1); push_pkt(1, 1);
    pushed1 = 1'b0;
    for (int i = 0; i < 300 && done_cnt < 5; i++) begin
      cyc();
      if (!pushed1 && s_gnt == 2'b01) begin
        push_pkt(1, 1);
        pushed1 = 1'b1;
      end
    end
    check_eq("str_done", done_cnt, 5);
    for (int k = 0; k < 5; k++) check_eq($sformatf("str_gnt%0d", k), grant_log[k], exp_str[k]);

    // Backpressure on the 2nd word of a 4-word packet
    strict_prio = 1'b0; weight_0 = 8'd1; weight_1 = 8'd1;
    do_reset();
    push_pkt(0, 4);
    bad_gnt = 0; low_cnt = 0; low_rd = 0; rd_cnt = 0; hold = 0;
    for (int i = 0; i < 300 && done_cnt < 1; i++) begin
      if (rd_cnt == 1 && hold < 2) begin
        out_rdy = 1'b0;
        hold++;
      end else begin
        out_rdy = 1'b1;
      end
      cyc();
      if (s_rd != 2'b00) rd_cnt++;
      if (s_gnt != 2'b00 && s_gnt != 2'b01) bad_gnt++;
      if (!out_rdy && s_gnt == 2'b01) low_cnt++;
      if (!out_rdy && s_rd != 2'b00) low_rd++;
    end
    out_rdy = 1'b1;
    check_eq("bp_done", done_cnt, 1);
    check_eq("bp_gnt_bad", bad_gnt, 0);
    check_eq("bp_low_cycles", low_cnt, 2);
    check_eq("bp_rd_when_low", low_rd, 0);
    check_eq("bp_reads", rd_cnt, 4);
    check_eq("bp_owr", ow_cnt, 4);
    check_eq("bp_cnt0", pkt_cnt_0, 16'd1);

    // Queue 1 empties mid-packet, refills 5 cycles later
    do_reset();
    fifo1.push_back(1'b0); fifo1.push_back(1'b0);
    refresh();
    bad_gnt = 0; stall = 0; pushed0 = 1'b0; pushed1 = 1'b0;
    for (int i = 0; i < 300 && done_cnt < 1; i++) begin
      cyc();
      if (s_gnt != 2'b00 && s_gnt != 2'b10) bad_gnt++;
      if (s_gnt == 2'b10 && fifo1.size() == 0 && !pushed1) stall++;
      if (stall == 1 && !pushed0) begin
        push_pkt(0, 1);
        pushed0 = 1'b1;
      end
      if (stall == 5 && !pushed1) begin
        fifo1.push_back(1'b1);
        refresh();
        pushed1 = 1'b1;
      end
    end
    check_eq("mpe_done", done_cnt, 1);
    check_eq("mpe_ngrants", grant_log.size(), 1);
    check_eq("mpe_gnt", grant_log[0], 2'b10);
    check_eq("mpe_gnt_bad", bad_gnt, 0);
    check_eq("mpe_stall", stall, 5);
    check_eq("mpe_owr", ow_cnt, 3);
    check_eq("mpe_cnt0", pkt_cnt_0, 16'd0);
    check_eq("mpe_cnt1", pkt_cnt_1, 16'd1);

    // Zero weight: reload cycle between every Q1 packet
    weight_0 = 8'd3; weight_1 = 8'd0;
    do_reset();
    push_pkt(1, 1); push_pkt(1, 1); push_pkt(1, 1);
    for (int i = 0; i < 300 && done_cnt < 3; i++) cyc();
    check_eq("zw_done", done_cnt, 3);
    check_eq("zw_gnt2", grant_log[2], 2'b10);
    check_eq("zw_gap1", gstart[1] - gstart[0], 4);
    check_eq("zw_gap2", gstart[2] - gstart[1], 4);
    check_eq("zw_cnt1", pkt_cnt_1, 16'd3);

    // Reset during SEND
    push_pkt(0, 4);
    rd_cnt = 0;
    for (int i = 0; i < 300 && rd_cnt == 0; i++) begin
      cyc();
      if (s_gnt == 2'b01 && s_rd == 2'b01) rd_cnt++;
    end
    check_eq("rm_reached", rd_cnt, 1);
    reset = 1'b1;
    cyc();
    check_eq("rm_gnt", queue_out_en, 2'b00);
    check_eq("rm_total", total_queue_out_en, 1'b0);
    check_eq("rm_rd", queue_rd_en, 2'b00);
    check_eq("rm_owr", out_wr, 1'b0);
    check_eq("rm_cnt0", pkt_cnt_0, 16'd0);
    check_eq("rm_cnt1", pkt_cnt_1, 16'd0);
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
